// File: rtl/pll_rst_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
package pll_rst_seq_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    localparam int LOSS_CNT_W = 8;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [LOSS_CNT_W-1:0] sat_inc(input logic [LOSS_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pll_rst_seq_sync_2ff.sv
// Two-flop synchronizer for asynchronous status inputs; clears to zero on srst.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk) begin
        if (srst) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset sequencer: pulses the PLL reset, qualifies lock with a stability
// window and a timeout (bounded retries), then releases downstream resets in order.
module pll_rst_seq
    import pll_rst_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRY           = 3,
    parameter int NUM_RST             = 2,
    parameter int RST_GAP_CYCLES      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  restart,
    input  logic                  pll_lock,
    output logic                  pll_rst,
    output logic [NUM_RST-1:0]    rst_out,
    output logic                  ready,
    output logic                  fail,
    output logic [2:0]            state,
    output logic [LOSS_CNT_W-1:0] loss_cnt
);

    localparam int RST_W = $clog2(PLL_RST_CYCLES + 1);
    localparam int STB_W = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int TMO_W = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam int RTY_W = $clog2(MAX_RETRY + 1);
    localparam int GAP_W = $clog2(RST_GAP_CYCLES + 1);
    localparam int IDX_W = $clog2(NUM_RST + 1);

    // Each counter holds "cycles already spent", so the last cycle is param-1.
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(PLL_RST_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRY - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(RST_GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_ALL  = IDX_W'(NUM_RST);

    state_t                  state_reg, state_next;
    logic [RST_W-1:0]        rst_cnt_reg, rst_cnt_next;
    logic [STB_W-1:0]        stable_cnt_reg, stable_cnt_next;
    logic [TMO_W-1:0]        tmo_cnt_reg, tmo_cnt_next;
    logic [RTY_W-1:0]        retry_reg, retry_next;
    logic [GAP_W-1:0]        gap_cnt_reg, gap_cnt_next;
    logic [IDX_W-1:0]        rel_idx_reg, rel_idx_next;   // number of rst_out bits released
    logic [LOSS_CNT_W-1:0]   loss_reg, loss_next;
    logic                    pll_rst_reg, pll_rst_next;
    logic [NUM_RST-1:0]      rst_out_reg, rst_out_next;
    logic                    ready_reg, ready_next;
    logic                    fail_reg, fail_next;
    logic                    lock_s;
    logic                    sync_srst;

    // Lock reported while the PLL is held in reset is meaningless, so the
    // synchronizer is kept clear then; each attempt observes lock afresh.
    assign sync_srst = rst | pll_rst_reg;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk  (clk),
        .srst (sync_srst),
        .d    (pll_lock),
        .q    (lock_s)
    );

    // Bit gi stays in reset until gi+1 bits have been released.
    for (genvar gi = 0; gi < NUM_RST; gi++) begin : g_rst_out
        assign rst_out_next[gi] = (IDX_W'(gi) >= rel_idx_next);
    end

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_PLL_RST;
            rst_cnt_reg    <= '0;
            stable_cnt_reg <= '0;
            tmo_cnt_reg    <= '0;
            retry_reg      <= '0;
            gap_cnt_reg    <= '0;
            rel_idx_reg    <= '0;
            loss_reg       <= '0;
            pll_rst_reg    <= 1'b1;
            rst_out_reg    <= '1;
            ready_reg      <= 1'b0;
            fail_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            rst_cnt_reg    <= rst_cnt_next;
            stable_cnt_reg <= stable_cnt_next;
            tmo_cnt_reg    <= tmo_cnt_next;
            retry_reg      <= retry_next;
            gap_cnt_reg    <= gap_cnt_next;
            rel_idx_reg    <= rel_idx_next;
            loss_reg       <= loss_next;
            pll_rst_reg    <= pll_rst_next;
            rst_out_reg    <= rst_out_next;
            ready_reg      <= ready_next;
            fail_reg       <= fail_next;
        end
    end

    // Next-state, counter and output decode; restart overrides every transition.
    always_comb begin
        state_next      = state_reg;
        rst_cnt_next    = rst_cnt_reg;
        stable_cnt_next = stable_cnt_reg;
        tmo_cnt_next    = tmo_cnt_reg;
        retry_next      = retry_reg;
        gap_cnt_next    = gap_cnt_reg;
        rel_idx_next    = rel_idx_reg;
        loss_next       = loss_reg;

        if (restart) begin
            state_next      = ST_PLL_RST;
            rst_cnt_next    = '0;
            stable_cnt_next = '0;
            tmo_cnt_next    = '0;
            retry_next      = '0;
            gap_cnt_next    = '0;
            rel_idx_next    = '0;
        end else begin
            case (state_reg)
                ST_PLL_RST: begin
                    if (rst_cnt_reg == RST_LAST) begin
                        state_next      = ST_WAIT_LOCK;
                        rst_cnt_next    = '0;
                        stable_cnt_next = '0;
                        tmo_cnt_next    = '0;
                    end else begin
                        rst_cnt_next = rst_cnt_reg + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    tmo_cnt_next    = tmo_cnt_reg + 1'b1;
                    stable_cnt_next = lock_s ? stable_cnt_reg + 1'b1 : '0;
                    // Qualified lock is checked first so it wins a tie with the timeout.
                    if (lock_s && (stable_cnt_reg == STB_LAST)) begin
                        state_next      = ST_RELEASE;
                        retry_next      = '0;
                        rel_idx_next    = IDX_W'(1);
                        gap_cnt_next    = '0;
                        stable_cnt_next = '0;
                        tmo_cnt_next    = '0;
                    end else if (tmo_cnt_reg == TMO_LAST) begin
                        retry_next      = retry_reg + 1'b1;
                        rst_cnt_next    = '0;
                        stable_cnt_next = '0;
                        tmo_cnt_next    = '0;
                        state_next      = (retry_reg == RTY_LAST) ? ST_FAIL : ST_PLL_RST;
                    end
                end
                ST_RELEASE: begin
                    if (!lock_s) begin
                        state_next   = ST_PLL_RST;
                        rst_cnt_next = '0;
                        gap_cnt_next = '0;
                        rel_idx_next = '0;
                    end else if (gap_cnt_reg == GAP_LAST) begin
                        gap_cnt_next = '0;
                        if (rel_idx_reg == IDX_ALL) begin
                            state_next = ST_RUN;
                        end else begin
                            rel_idx_next = rel_idx_reg + 1'b1;
                        end
                    end else begin
                        gap_cnt_next = gap_cnt_reg + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_next   = ST_PLL_RST;
                        rst_cnt_next = '0;
                        rel_idx_next = '0;
                        loss_next    = sat_inc(loss_reg);
                    end
                end
                ST_FAIL: begin
                    state_next = ST_FAIL;
                end
                default: begin
                    state_next   = ST_PLL_RST;
                    rst_cnt_next = '0;
                    rel_idx_next = '0;
                end
            endcase
        end

        pll_rst_next = (state_next == ST_PLL_RST) || (state_next == ST_FAIL);
        ready_next   = (state_next == ST_RUN);
        fail_next    = (state_next == ST_FAIL);
    end

    assign pll_rst  = pll_rst_reg;
    assign rst_out  = rst_out_reg;
    assign ready    = ready_reg;
    assign fail     = fail_reg;
    assign state    = state_reg;
    assign loss_cnt = loss_reg;

endmodule

// File: doc/pll_rst_seq.md
Name: pll_rst_seq

Overview:
- Controller for the board clock PLL (50 MHz in, generated clock out, lock flag).
- Drives the PLL reset and qualifies lock with a stability window and a timeout, retrying a bounded number of times.
- Releases NUM_RST downstream reset domains in a staggered order.
- Runs on the free-running PLL input clock; any lock loss re-enters the sequence.

Parameters:
- PLL_RST_CYCLES, 16, cycles pll_rst is held high per attempt (>=1).
- LOCK_STABLE_CYCLES, 1024, consecutive synchronized-lock cycles needed to qualify lock.
- LOCK_TIMEOUT_CYCLES, 65536, max cycles in WAIT_LOCK per attempt before a retry.
- MAX_RETRY, 3, failed attempts allowed before entering FAIL (>=1).
- NUM_RST, 2, number of downstream reset outputs (>=1).
- RST_GAP_CYCLES, 16, cycles between successive rst_out releases (>=1).

Ports:
- clk  in  1  free-running PLL reference clock
- rst  in  1  synchronous, active-high reset
- restart  in  1  single-cycle request: abort and start a fresh sequence, retries cleared
- pll_lock  in  1  PLL lock, asynchronous to clk
- pll_rst  out  1  PLL reset, active-high
- rst_out  out  NUM_RST  downstream resets, active-high; bit 0 released first
- ready  out  1  all rst_out released, lock qualified
- fail  out  1  retry budget exhausted
- state  out  3  FSM state code
- loss_cnt  out  8  saturating count of lock losses after ready was reached

Behaviour:
- Clock and reset:
  - One clock; rst is synchronous, active-high.
  - While rst is high: pll_rst=1, rst_out=all 1s, ready=0, fail=0, state=PLL_RST, loss_cnt=0, counters=0, synchronizer=0.
- Synchronizer and output timing:
  - pll_lock passes through a 2-flop synchronizer to give lock_s.
  - All outputs are registered.
  - An edge of pll_lock affects outputs 3 clk edges later.
- State codes: PLL_RST=0, WAIT_LOCK=1, RELEASE=2, RUN=3, FAIL=4.
- PLL_RST:
  - pll_rst=1; count PLL_RST_CYCLES, then go to WAIT_LOCK.
  - The first cycle after rst falls counts as cycle 1.
- WAIT_LOCK:
  - pll_rst=0.
  - The timeout counter increments every cycle.
  - The stable counter increments while lock_s=1 and clears when lock_s=0.
  - Stable counter reaches LOCK_STABLE_CYCLES -> RELEASE; clear retry count.
  - Otherwise, timeout counter reaches LOCK_TIMEOUT_CYCLES -> retry+1:
    - retry == MAX_RETRY -> FAIL
    - else -> PLL_RST
  - If both conditions hit in the same cycle, stable wins.
- RELEASE:
  - On entry, rst_out[0] drops.
  - Each further bit drops RST_GAP_CYCLES after the previous one.
  - RST_GAP_CYCLES after the last bit drops -> RUN.
- RUN: ready=1.
- Lock loss (lock_s=0 in RELEASE or RUN):
  - Next registered cycle: rst_out=all 1s, ready=0, go to PLL_RST.
  - loss_cnt+1, saturating at 255; counted only if loss occurs in RUN.
- FAIL:
  - pll_rst=1, rst_out=all 1s, fail=1.
  - Exited only by rst or restart.
- restart (any state):
  - Next cycle: go to PLL_RST with counters and retries cleared, fail=0, rst_out=all 1s, ready=0.
  - loss_cnt is kept.
  - restart has priority over all other transitions; rst has priority over restart.
- Counter widths: $clog2(param+1); no counter wraps, each resets on state entry.
- rst_out is monotonic within one pass: bits only drop in RELEASE and all rise together.

Decomposition:
- Package pll_rst_seq_pkg: state_t enum with codes above; LOSS_CNT_W=8.
- Sub-module sync_2ff (parameterised width, reset value 0) for pll_lock.
- It is reusable for other async status inputs.

Test Plan:
All scenarios use PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRY=2, NUM_RST=2, RST_GAP_CYCLES=4.
- Nominal: release rst with pll_lock tied 1.
  - -> pll_rst high exactly 4 cycles.
  - -> rst_out[0] falls 10 cycles after pll_rst falls (2 sync + 8 stable).
  - -> rst_out[1] falls 4 later; ready rises 4 after that; state=3.
- Lock glitch in WAIT_LOCK: pll_lock low 1 cycle after 6 stable cycles.
  - -> stable restarts; rst_out[0] falls 8 cycles after glitch clears in lock_s.
  - -> no retry.
- Timeout/fail: pll_lock held 0.
  - -> two 4-cycle pll_rst pulses separated by 32 cycles.
  - -> after second timeout: state=4, fail=1, pll_rst=1, rst_out=2'b11.
- Loss in RUN: drop pll_lock after ready.
  - -> 3 edges later rst_out=2'b11, ready=0, pll_rst=1, loss_cnt=1.
  - -> full sequence repeats when lock returns.
- Restart from FAIL and mid-RELEASE: pulse restart.
  - -> next cycle state=0, fail=0, rst_out=2'b11, loss_cnt unchanged.
  - -> nominal sequence follows.
- Saturation and reset priority:
  - Force 256 RUN losses -> loss_cnt stays 255.
  - Assert rst and restart together -> reset values, loss_cnt=0.
